// File: rtl/timer_evt_pkg.sv
// Shared types and constants for the multi-channel timer event/status block.
//   evt_mode_t  : per-channel edge/level selection
//   MAX_CH      : largest supported channel count
//   PULSE_CNT_W : width of the per-channel pulse stretch counter
//   evt_detect  : combinational event detect for one channel
package timer_evt_pkg;

  typedef enum logic [1:0] {
    EVT_RISE  = 2'b00,
    EVT_FALL  = 2'b01,
    EVT_BOTH  = 2'b10,
    EVT_LEVEL = 2'b11
  } evt_mode_t;

  localparam int unsigned MAX_CH      = 16;
  localparam int unsigned PULSE_CNT_W = 8;

  // Raw (unqualified) event for the selected mode.
  function automatic logic evt_detect(input evt_mode_t mode, input logic tc,
                                      input logic tc_prev);
    logic evt;
    evt = 1'b0;
    case (mode)
      EVT_RISE:  evt = tc & ~tc_prev;
      EVT_FALL:  evt = ~tc & tc_prev;
      EVT_BOTH:  evt = tc ^ tc_prev;
      EVT_LEVEL: evt = tc;
      default:   evt = 1'b0;
    endcase
    return evt;
  endfunction

endpackage

// File: rtl/timer_evt_channel.sv
// One timer terminal-count channel: edge detect, pulse stretcher, sticky
// status and (with TIMER_EVT_COUNT_EN defined) a saturating event counter.
// Ports:
//   clk, reset     : clock, async active-high reset
//   tc             : terminal-count input
//   enable         : detection enable; low kills any active pulse
//   mode           : edge/level selection
//   clear          : acknowledge; clears sticky and counter
//   evt_pulse      : registered stretched event pulse
//   sticky         : registered latched-event status
//   sticky_nxt_c   : combinational next-state of sticky
//   event_count    : saturating event counter (constant 0 when disabled)
module timer_evt_channel
  import timer_evt_pkg::*;
#(
  parameter int unsigned PULSE_LEN = 1,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tc,
  input  logic             enable,
  input  evt_mode_t        mode,
  input  logic             clear,
  output logic             evt_pulse,
  output logic             sticky,
  output logic             sticky_nxt_c,
  output logic [CNT_W-1:0] event_count
);

  logic                   r_tc_prev;
  logic [PULSE_CNT_W-1:0] r_pulse_cnt;
  logic                   r_evt_pulse;
  logic                   r_sticky;
  logic                   w_evt;
  logic [PULSE_CNT_W-1:0] w_pulse_cnt_nxt;

  // Event detect and pulse counter next state; a retrigger reloads the count.
  always_comb begin
    w_evt           = enable & evt_detect(mode, tc, r_tc_prev);
    w_pulse_cnt_nxt = r_pulse_cnt;
    if (!enable) begin
      w_pulse_cnt_nxt = '0;
    end else if (w_evt) begin
      w_pulse_cnt_nxt = PULSE_CNT_W'(PULSE_LEN);
    end else if (r_pulse_cnt != '0) begin
      w_pulse_cnt_nxt = r_pulse_cnt - PULSE_CNT_W'(1);
    end
  end

  // Set wins over clear.
  assign sticky_nxt_c = w_evt | (r_sticky & ~clear);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tc_prev   <= 1'b0;
      r_pulse_cnt <= '0;
      r_evt_pulse <= 1'b0;
      r_sticky    <= 1'b0;
    end else begin
      r_tc_prev   <= tc;
      r_pulse_cnt <= w_pulse_cnt_nxt;
      r_evt_pulse <= (w_pulse_cnt_nxt != '0);
      r_sticky    <= sticky_nxt_c;
    end
  end

  assign evt_pulse = r_evt_pulse;
  assign sticky    = r_sticky;

`ifdef TIMER_EVT_COUNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;

  // Saturating counter; clear with a coincident event restarts at 1.
  always_comb begin
    w_count_nxt = r_count;
    if (clear) begin
      w_count_nxt = w_evt ? CNT_W'(1) : '0;
    end else if (w_evt && (r_count != CNT_MAX)) begin
      w_count_nxt = r_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_nxt;
    end
  end

  assign event_count = r_count;
`else
  assign event_count = '0;
`endif

endmodule

// File: rtl/timer_event_status_multi.sv
// Multi-channel timer terminal-count event/status block.
// Optional feature macro: TIMER_EVT_COUNT_EN (per-channel event counters).
// Ports:
//   clk, reset   : clock, async active-high reset
//   tc           : NUM_CH terminal-count inputs
//   enable       : per-channel detection enable
//   mode         : per-channel evt_mode_t, channel i at [2i+1:2i]
//   clear        : per-channel acknowledge
//   evt_pulse    : per-channel stretched event pulse
//   sticky       : per-channel latched-event status
//   any_sticky   : OR of sticky
//   first_ch     : lowest-index set sticky bit, 0 when none
//   event_count  : per-channel saturating counters, channel i at CNT_W*i
module timer_event_status_multi
  import timer_evt_pkg::*;
#(
  parameter  int unsigned NUM_CH    = 4,
  parameter  int unsigned PULSE_LEN = 1,
  parameter  int unsigned CNT_W     = 8,
  localparam int unsigned FC_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       tc,
  input  logic [NUM_CH-1:0]       enable,
  input  logic [2*NUM_CH-1:0]     mode,
  input  logic [NUM_CH-1:0]       clear,
  output logic [NUM_CH-1:0]       evt_pulse,
  output logic [NUM_CH-1:0]       sticky,
  output logic                    any_sticky,
  output logic [FC_W-1:0]         first_ch,
  output logic [NUM_CH*CNT_W-1:0] event_count
);

  logic [NUM_CH-1:0] w_sticky_nxt;
  logic [FC_W-1:0]   w_first_ch;
  logic [FC_W-1:0]   r_first_ch;
  logic              r_any_sticky;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    timer_evt_channel #(
      .PULSE_LEN(PULSE_LEN),
      .CNT_W    (CNT_W)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .tc          (tc[i]),
      .enable      (enable[i]),
      .mode        (evt_mode_t'(mode[2*i +: 2])),
      .clear       (clear[i]),
      .evt_pulse   (evt_pulse[i]),
      .sticky      (sticky[i]),
      .sticky_nxt_c(w_sticky_nxt[i]),
      .event_count (event_count[CNT_W*i +: CNT_W])
    );
  end

  // Lowest-index priority encode on next-state sticky so it lines up with sticky.
  always_comb begin
    w_first_ch = '0;
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      if (w_sticky_nxt[i]) begin
        w_first_ch = FC_W'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_first_ch   <= '0;
      r_any_sticky <= 1'b0;
    end else begin
      r_first_ch   <= w_first_ch;
      r_any_sticky <= |w_sticky_nxt;
    end
  end

  assign first_ch   = r_first_ch;
  assign any_sticky = r_any_sticky;

endmodule

// File: tb/tb_timer_event_status_multi.sv
// Scoreboard bench: two instances (PULSE_LEN=1/CNT_W=8 and PULSE_LEN=3/CNT_W=2).
module tb_timer_event_status_multi;
  import timer_evt_pkg::*;

`ifdef TIMER_EVT_COUNT_EN
  localparam bit COUNT_EN = 1'b1;
`else
  localparam bit COUNT_EN = 1'b0;
`endif

  typedef struct {
    bit         chk_ps;
    bit         chk_c;
    logic [3:0] p;
    logic [3:0] s;
    logic [1:0] f;
    int         cch;
    logic [7:0] c;
    int         id;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b;
  logic [3:0]  tc_a, en_a, clr_a, tc_b, en_b, clr_b;
  logic [7:0]  mode_a, mode_b;
  logic [3:0]  pulse_a, sticky_a, pulse_b, sticky_b;
  logic        any_a, any_b;
  logic [1:0]  first_a, first_b;
  logic [31:0] cnt_a;
  logic [7:0]  cnt_b;

  timer_event_status_multi #(.NUM_CH(4), .PULSE_LEN(1), .CNT_W(8)) dut_a (
    .clk(clk), .reset(rst_a), .tc(tc_a), .enable(en_a), .mode(mode_a), .clear(clr_a),
    .evt_pulse(pulse_a), .sticky(sticky_a), .any_sticky(any_a), .first_ch(first_a),
    .event_count(cnt_a)
  );

  timer_event_status_multi #(.NUM_CH(4), .PULSE_LEN(3), .CNT_W(2)) dut_b (
    .clk(clk), .reset(rst_b), .tc(tc_b), .enable(en_b), .mode(mode_b), .clear(clr_b),
    .evt_pulse(pulse_b), .sticky(sticky_b), .any_sticky(any_b), .first_ch(first_b),
    .event_count(cnt_b)
  );

  int   n_chk  = 0;
  int   n_fail = 0;
  int   step   = 0;
  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  task automatic chk(input string name, input int id, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: actual %0h required %0h", name, id, act, exp);
    end
  endtask

  function automatic logic [7:0] ce(input logic [7:0] v);
    return v & {8{COUNT_EN}};
  endfunction

  task automatic ea_ps(input logic [3:0] p, input logic [3:0] s, input logic [1:0] f);
    ea.chk_ps = 1'b1; ea.p = p; ea.s = s; ea.f = f;
  endtask
  task automatic ea_c(input int ch, input logic [7:0] c);
    ea.chk_c = 1'b1; ea.cch = ch; ea.c = ce(c);
  endtask
  task automatic eb_ps(input logic [3:0] p, input logic [3:0] s, input logic [1:0] f);
    eb.chk_ps = 1'b1; eb.p = p; eb.s = s; eb.f = f;
  endtask
  task automatic eb_c(input int ch, input logic [7:0] c);
    eb.chk_c = 1'b1; eb.cch = ch; eb.c = ce(c);
  endtask

  // Push this cycle's expectations, then move to the next drive point.
  task automatic nxt();
    step++;
    ea.id = step;
    eb.id = step;
    qa.push_back(ea);
    qb.push_back(eb);
    ea = '{default: 0};
    eb = '{default: 0};
    @(negedge clk);
  endtask

  task automatic cmp(input string tag, input exp_t e, input logic [3:0] p,
                     input logic [3:0] s, input logic a, input logic [1:0] f,
                     input logic [7:0] c);
    if (e.chk_ps) begin
      chk({tag, "_pulse"}, e.id, 32'(p), 32'(e.p));
      chk({tag, "_sticky"}, e.id, 32'(s), 32'(e.s));
      chk({tag, "_any"}, e.id, 32'(a), 32'(|e.s));
      chk({tag, "_first"}, e.id, 32'(f), 32'(e.f));
    end
    if (e.chk_c) chk({tag, "_count"}, e.id, 32'(c), 32'(e.c));
  endtask

  // Monitor: one expectation per DUT per clock, sampled just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (qa.size() > 0) begin
        e = qa.pop_front();
        cmp("a", e, pulse_a, sticky_a, any_a, first_a, cnt_a[e.cch*8 +: 8]);
      end
      if (qb.size() > 0) begin
        e = qb.pop_front();
        cmp("b", e, pulse_b, sticky_b, any_b, first_b, 8'(cnt_b[e.cch*2 +: 2]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    ea = '{default: 0};
    eb = '{default: 0};
    rst_a = 1'b1; rst_b = 1'b1;
    tc_a = 4'b0001; en_a = 4'hF; mode_a = 8'h00; clr_a = 4'h0;
    tc_b = 4'b0000; en_b = 4'hF; mode_b = 8'h00; clr_b = 4'h0;
    repeat (3) @(negedge clk);
    chk("rst_a_pulse", 0, 32'(pulse_a), 0);
    chk("rst_a_sticky", 0, 32'(sticky_a), 0);
    chk("rst_a_any", 0, 32'(any_a), 0);
    chk("rst_a_count", 0, cnt_a, 0);
    chk("rst_b_pulse", 0, 32'(pulse_b), 0);
    rst_a = 1'b0; rst_b = 1'b0;

    // tc[0] high at reset release counts as one rise
    ea_ps(4'b0001, 4'b0001, 2'd0); ea_c(0, 1); nxt();
    ea_ps(4'b0000, 4'b0001, 2'd0); ea_c(0, 1); nxt();
    clr_a = 4'b0001; ea_ps(4'b0000, 4'b0000, 2'd0); ea_c(0, 0); nxt();
    clr_a = 4'b0000; tc_a = 4'b0000; ea_ps(4'b0000, 4'b0000, 2'd0); nxt();

    // ch2 FALL: nothing on the rise or while high, one pulse after the fall
    mode_a = 8'b00_01_00_00;
    tc_a = 4'b0100; ea_ps(4'b0000, 4'b0000, 2'd0); nxt();
    repeat (4) begin ea_ps(4'b0000, 4'b0000, 2'd0); nxt(); end
    tc_a = 4'b0000; ea_ps(4'b0100, 4'b0100, 2'd2); ea_c(2, 1); nxt();
    ea_ps(4'b0000, 4'b0100, 2'd2); nxt();

    // ch2 BOTH: pulse on each edge
    mode_a = 8'b00_10_00_00;
    tc_a = 4'b0100; ea_ps(4'b0100, 4'b0100, 2'd2); ea_c(2, 2); nxt();
    ea_ps(4'b0000, 4'b0100, 2'd2); nxt();
    tc_a = 4'b0000; ea_ps(4'b0100, 4'b0100, 2'd2); ea_c(2, 3); nxt();
    ea_ps(4'b0000, 4'b0100, 2'd2); nxt();
    clr_a = 4'b0100; ea_ps(4'b0000, 4'b0000, 2'd0); ea_c(2, 0); nxt();
    clr_a = 4'b0000; mode_a = 8'h00; ea_ps(4'b0000, 4'b0000, 2'd0); nxt();

    // sticky on ch1/ch3, clear ch1 then clear ch3 with a coincident event
    tc_a = 4'b1010; ea_ps(4'b1010, 4'b1010, 2'd1); ea_c(3, 1); nxt();
    tc_a = 4'b0000; ea_ps(4'b0000, 4'b1010, 2'd1); nxt();
    tc_a = 4'b1000; ea_ps(4'b1000, 4'b1010, 2'd1); ea_c(3, 2); nxt();
    tc_a = 4'b0000; clr_a = 4'b0010; ea_ps(4'b0000, 4'b1000, 2'd3); ea_c(1, 0); nxt();
    tc_a = 4'b1000; clr_a = 4'b1000; ea_ps(4'b1000, 4'b1000, 2'd3); ea_c(3, 1); nxt();
    tc_a = 4'b0000; clr_a = 4'b0000; ea_ps(4'b0000, 4'b1000, 2'd3); ea_c(3, 1); nxt();

    // B, PULSE_LEN=3: retrigger at t+2 gives one continuous 5-cycle pulse
    tc_b = 4'b0010; eb_ps(4'b0010, 4'b0010, 2'd1); eb_c(1, 1); nxt();
    tc_b = 4'b0000; eb_ps(4'b0010, 4'b0010, 2'd1); nxt();
    tc_b = 4'b0010; eb_ps(4'b0010, 4'b0010, 2'd1); eb_c(1, 2); nxt();
    tc_b = 4'b0000; eb_ps(4'b0010, 4'b0010, 2'd1); nxt();
    eb_ps(4'b0010, 4'b0010, 2'd1); nxt();
    eb_ps(4'b0000, 4'b0010, 2'd1); eb_c(1, 2); nxt();
    clr_b = 4'b0010; eb_ps(4'b0000, 4'b0000, 2'd0); eb_c(1, 0); nxt();
    clr_b = 4'b0000; eb_ps(4'b0000, 4'b0000, 2'd0); nxt();

    // B ch0 LEVEL, CNT_W=2: counter saturates at 3
    mode_b = 8'b00_00_00_11;
    tc_b = 4'b0001;
    for (int k = 1; k <= 6; k++) begin
      eb_ps(4'b0001, 4'b0001, 2'd0); eb_c(0, 8'((k > 3) ? 3 : k)); nxt();
    end
    // enable dropped mid-pulse: pulse low next cycle, sticky and count hold
    en_b = 4'b1110; eb_ps(4'b0000, 4'b0001, 2'd0); eb_c(0, 3); nxt();
    tc_b = 4'b0000; eb_ps(4'b0000, 4'b0001, 2'd0); nxt();
    en_b = 4'hF; mode_b = 8'h00; eb_ps(4'b0000, 4'b0001, 2'd0); nxt();

    // ch2 pulse in progress, then async reset between clock edges
    tc_b = 4'b0100; eb_ps(4'b0100, 4'b0101, 2'd0); eb_c(2, 1); nxt();
    tc_b = 4'b0000; eb_ps(4'b0100, 4'b0101, 2'd0); nxt();
    rst_b = 1'b1;
    #1;
    chk("async_rst_pulse", step, 32'(pulse_b), 0);
    chk("async_rst_sticky", step, 32'(sticky_b), 0);
    chk("async_rst_any", step, 32'(any_b), 0);
    chk("async_rst_first", step, 32'(first_b), 0);
    chk("async_rst_count", step, 32'(cnt_b), 0);
    @(negedge clk);
    rst_b = 1'b0;
    eb_ps(4'b0000, 4'b0000, 2'd0); eb_c(2, 0); nxt();

    chk("queue_drain", step, 32'(qa.size() + qb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
